// File: rtl/uart_rx_if.sv
// Receive-side output bundle of uart_rx_core, carried as one interface.
// valid_o and ferr_o are one-cycle strobes with no ready: the consumer must take dout_o on the valid_o cycle.
interface uart_rx_if #(
  parameter int DataBits = 8
);
  logic [DataBits-1:0] dout_o;
  logic                valid_o;
  logic                ferr_o;

  modport master (output dout_o, valid_o, ferr_o);
  modport slave  (input  dout_o, valid_o, ferr_o);
endinterface

// File: rtl/uart_rx_core.sv
// UART receive engine: synchronises rx_i, validates the start bit, samples data at mid-bit
// LSB first, checks the stop bit and emits either a byte strobe or a framing-error strobe.
module uart_rx_core #(
  parameter int BaudDiv  = 434,
  parameter int DataBits = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_i,
  output logic             busy_o,
  output logic [2:0]       dbg_state_o,
  uart_rx_if.master        rx_if_o
);

  localparam int CntW = $clog2(BaudDiv);
  localparam int BitW = $clog2(DataBits + 1);
  localparam int H    = BaudDiv / 2;

  localparam logic [CntW-1:0] CntHalf = CntW'(H - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(BaudDiv - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DataBits - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic                  sync1_q, sync2_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DataBits-1:0]   sh_q, sh_d;
  logic [DataBits-1:0]   dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  busy_q;
  logic                  sample;
  logic                  rx_s;

  assign rx_s = sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_q != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    sample  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        // Mid-start-bit check: a line back high here was only a glitch.
        if (cnt_q == CntHalf) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (cnt_q == CntFull) begin
          sample = 1'b1;
          sh_d   = {rx_s, sh_q[DataBits-1:1]};
          bit_d  = bit_q + 1'b1;
          if (bit_q == BitLast) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CntFull) begin
          sample = 1'b1;
          if (rx_s) begin
            dout_d  = sh_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        // Wait out a held-low line so it is not mistaken for a new start bit.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if ((state_d != state_q) || sample) cnt_d = '0;
    if ((state_d == DATA) && (state_q != DATA)) bit_d = '0;
  end

  assign rx_if_o.dout_o  = dout_q;
  assign rx_if_o.valid_o = valid_q;
  assign rx_if_o.ferr_o  = ferr_q;
  assign busy_o          = busy_q;
  assign dbg_state_o     = state_q;

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receive engine for the RS-232 receive path. It synchronises the raw `rx_i` line, detects and validates the start bit, and times each bit with an internal baud counter. It samples the data bits at mid-bit, LSB first, into a shift register, then checks the stop bit. On a good frame it presents a byte with a one-cycle valid strobe to the downstream consumer; on a bad stop bit it raises a framing-error strobe.

## Interface
- `BaudDiv`, 434: clock cycles per bit period (434 = 50 MHz / 115200); legal range 4..65535.
- `DataBits`, 8: data bits per frame; legal range 5..8.
- `clk_i`  input  1  system clock; all logic on rising edge.
- `rst_i`  input  1  reset; one clock; reset is synchronous and active-high.
- `rx_i`  input  1  raw asynchronous serial line, idle high.
- `dout_o`  output  DataBits  last correctly received byte, LSB = first data bit.
- `valid_o`  output  1  one-cycle pulse: `dout_o` updated this cycle.
- `ferr_o`  output  1  one-cycle pulse: stop bit sampled low.
- `busy_o`  output  1  high whenever the FSM is not in IDLE.

## Operation
- Synchroniser: two flip-flops on `rx_i`, both reset to 1; the FSM sees only the second stage, `rx_s`.
- Baud counter: width `clog2(BaudDiv)`. It is cleared to 0 on every state entry and on every bit sample. Otherwise it increments by 1 each cycle. `H = BaudDiv/2` (floor).
- Bit counter: width `clog2(DataBits+1)`. Cleared on entry to DATA; incremented on each data sample.
- Shift register: on each data sample, `sh <= {rx_s, sh[DataBits-1:1]}` (shift right, new bit in at MSB).
- FSM states and transitions:
  - IDLE:
    - `rx_s==0` -> START.
  - START:
    - When `cnt==H-1` and `rx_s==0` -> DATA.
    - When `cnt==H-1` and `rx_s==1` -> IDLE (glitch rejected, no strobe).
  - DATA:
    - When `cnt==BaudDiv-1`, sample into the shift register.
    - After the DataBits-th sample -> STOP.
  - STOP, when `cnt==BaudDiv-1`:
    - `rx_s==1`: `dout_o<=sh`, `valid_o<=1`, -> IDLE.
    - `rx_s==0`: `ferr_o<=1`, `dout_o` unchanged, -> BREAK.
  - BREAK:
    - `rx_s==1` -> IDLE.
    - No start detection while the line is low.
- Returning to IDLE at mid-stop-bit allows back-to-back frames with no idle gap.
- `valid_o` and `ferr_o` are never high in the same cycle. Each is high for exactly one cycle per frame.
- Reset mid-frame aborts the frame: no strobe, state IDLE, counters and shift register cleared.

## Timing
- Reset values:
  - state IDLE; synchroniser = 1.
  - `dout_o` = 0; `valid_o` = 0; `ferr_o` = 0; `busy_o` = 0.
  - Baud counter, bit counter and shift register = 0.
- Let E0 be the first clock edge that samples `rx_i` low.
  - START is entered at E0+2.
  - The start check is at E0+2+H.
  - Data bit k (k = 0..DataBits-1) is sampled at E0+2+H+(k+1)·BaudDiv.
  - The stop bit is sampled at E0+2+H+(DataBits+1)·BaudDiv.
  - `valid_o`/`ferr_o` are high for the cycle after the stop-sample edge.
  - Example: BaudDiv=16, DataBits=8 gives the strobe after edge E0+154.
- `busy_o` rises one cycle after START entry (registered from state) and falls the cycle after the FSM returns to IDLE.
- Outputs are registered; there is no combinational path from `rx_i`.
- Sampling jitter is at most 1 clock plus 2 synchroniser cycles. A nominal mid-bit sample tolerates baud mismatch up to about ±4 % at DataBits = 8.

## Test plan
All scenarios use BaudDiv=16, DataBits=8, `rx_i` idle high unless noted.
- Reset: assert `rst_i` for 3 cycles with `rx_i`=1 -> `dout_o`=0x00, `valid_o`=`ferr_o`=`busy_o`=0; all remain so for 100 idle cycles.
- Good frame: send 0xA5 (start 0; bits 1,0,1,0,0,1,0,1; stop 1) -> single `valid_o` pulse after edge E0+154, `dout_o`=0xA5, `ferr_o` never high, `busy_o` low at E0+156.
- Glitch: drive `rx_i` low for 4 cycles, then high -> no strobe; `busy_o` high from E0+3 and low again by E0+12; `dout_o` unchanged.
- Framing error: send 0x3C with stop bit 0, then hold `rx_i` low for 40 cycles, then high -> one `ferr_o` pulse, no `valid_o`, `dout_o` keeps 0xA5; `busy_o` stays high until 3 cycles after `rx_i` returns high; no new frame is started.
- Back-to-back: send 0x00 then 0xFF with the second start bit immediately after the first stop bit -> two `valid_o` pulses 160 cycles apart, `dout_o` = 0x00 then 0xFF.
- Reset mid-frame: assert `rst_i` for 1 cycle during data bit 3 of 0x81, then send 0x5A -> no strobe for 0x81; one `valid_o` with `dout_o`=0x5A.
